// File: rtl/ula_md_if.sv
// ula_md bus: operands and op selects in, ALU result and
// HI/LO mult/div status out.
interface ula_md_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [3:0]       OP;
  logic [1:0]       md_op;
  logic             md_start;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output In1, In2, OP, md_op, md_start,
    input  result, zero_flag, hi, lo,
    input  busy, done, div_by_zero
  );

  modport slave (
    input  In1, In2, OP, md_op, md_start,
    output result, zero_flag, hi, lo,
    output busy, done, div_by_zero
  );
endinterface

// File: rtl/ula_md.sv
// EX-stage ALU with iterative multiply/divide and HI/LO.
// Mult is shift-add, div is restoring, one bit per cycle.
module ula_md #(
  parameter int WIDTH = 32
) (
  input logic     clock,
  input logic     reset,
  ula_md_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   dsr, dvd;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_fx, lo_fx;
  logic [WIDTH-1:0]   res, mag1, mag2;
  logic [SHW-1:0]     cnt, shamt;
  logic [1:0]         op_q;
  logic               neg_q, neg_r, dz;
  logic               done_q, dbz_q;
  logic               s1, s2;
  logic [WIDTH:0]     madd, rsh, rdiff;

  always_comb begin
    shamt = bus.In2[SHW-1:0];
    res   = '0;
    case (bus.OP)
      4'b0000: res = bus.In1 & bus.In2;
      4'b0001: res = bus.In1 | bus.In2;
      4'b0010: res = bus.In1 + bus.In2;
      4'b0011: res = bus.In1 ^ bus.In2;
      4'b0110: res = bus.In1 - bus.In2;
      4'b1100: res = ~(bus.In1 | bus.In2);
      4'b0100,
      4'b1000: res = bus.In1 << shamt;
      4'b0101,
      4'b1001: res = bus.In1 >> shamt;
      4'b1010,
      4'b1101: res = $signed(bus.In1) >>> shamt;
      4'b0111: res = {{(WIDTH-1){1'b0}},
        $signed(bus.In1) < $signed(bus.In2)};
      4'b1111: res = {{(WIDTH-1){1'b0}},
        bus.In1 < bus.In2};
      4'b1011: res = hi_q;
      4'b1110: res = lo_q;
      default: res = '0;
    endcase
  end

  assign bus.result      = res;
  assign bus.zero_flag   = (res == '0);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

  // md_op[0] set means unsigned
  assign s1   = ~bus.md_op[0] & bus.In1[WIDTH-1];
  assign s2   = ~bus.md_op[0] & bus.In2[WIDTH-1];
  assign mag1 = s1 ? -bus.In1 : bus.In1;
  assign mag2 = s2 ? -bus.In2 : bus.In2;

  always_comb begin
    madd = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (acc[0] ? {1'b0, dsr} : {(WIDTH+1){1'b0}});
    rsh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rdiff = rsh - {1'b0, dsr};
    if (op_q[1]) begin
      if (rdiff[WIDTH])
        acc_nx = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nx = {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = {madd, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod  = neg_q ? -acc : acc;
    hi_fx = prod[2*WIDTH-1:WIDTH];
    lo_fx = prod[WIDTH-1:0];
    if (op_q[1]) begin
      lo_fx = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_fx = neg_r ? -acc[2*WIDTH-1:WIDTH]
                    : acc[2*WIDTH-1:WIDTH];
      if (dz) begin
        lo_fx = '1;
        hi_fx = dvd;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.md_start) state_nx = RUN;
      RUN:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      dsr    <= '0;
      dvd    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.md_start) begin
          acc   <= {{WIDTH{1'b0}}, mag1};
          dsr   <= mag2;
          dvd   <= bus.In1;
          cnt   <= SHW'(WIDTH-1);
          op_q  <= bus.md_op;
          neg_q <= s1 ^ s2;
          neg_r <= s1;
          dz    <= (bus.In2 == '0);
          dbz_q <= 1'b0;
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi_q   <= hi_fx;
          lo_q   <= lo_fx;
          done_q <= 1'b1;
          if (op_q[1]) dbz_q <= dz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_md.sv
// Directed bench for ula_md: ALU vector table plus
// hand-written mult/div handshake sequences.
module tb_ula_md;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ula_md_if #(.WIDTH(32)) bus();

  ula_md #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t v[17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic md_run(input string name,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    int lat;
    int bc;
    @(negedge clock);
    bus.md_op    = op;
    bus.In1      = a;
    bus.In2      = b;
    bus.md_start = 1'b1;
    @(posedge clock);
    #1;
    bus.md_start = 1'b0;
    bus.In1      = 32'hDEAD_BEEF;
    bus.In2      = 32'h0BAD_F00D;
    chk({name, " dbz_clr"}, {31'd0, bus.div_by_zero}, 0);
    lat = 0;
    bc  = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bc++;
      @(posedge clock);
      #1;
      lat++;
    end
    chk({name, " latency"}, lat, 33);
    chk({name, " busy_cycles"}, bc, 33);
    chk({name, " busy_done"}, {31'd0, bus.busy}, 0);
    chk({name, " hi"}, bus.hi, ehi);
    chk({name, " lo"}, bus.lo, elo);
    bus.OP = 4'b1011;
    #1;
    chk({name, " mfhi"}, bus.result, ehi);
    @(posedge clock);
    #1;
    chk({name, " done_pulse"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int lat;
    int seen;

    v[0]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    v[1]  = '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F};
    v[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    v[3]  = '{4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    v[4]  = '{4'b0110, 32'd5,        32'd5,        32'h00000000};
    v[5]  = '{4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE};
    v[6]  = '{4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF};
    v[7]  = '{4'b0100, 32'h1,        32'd31,       32'h80000000};
    v[8]  = '{4'b1000, 32'h3,        32'h24,       32'h00000030};
    v[9]  = '{4'b0101, 32'h80000000, 32'd31,       32'h00000001};
    v[10] = '{4'b1001, 32'hF0,       32'd4,        32'h0000000F};
    v[11] = '{4'b1010, 32'h80000000, 32'd4,        32'hF8000000};
    v[12] = '{4'b1101, 32'h7FFFFFFF, 32'd30,       32'h00000001};
    v[13] = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000001};
    v[14] = '{4'b1111, 32'hFFFFFFFF, 32'd1,        32'h00000000};
    v[15] = '{4'b0111, 32'd5,        32'hFFFFFFFF, 32'h00000000};
    v[16] = '{4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000};

    reset        = 1'b1;
    bus.In1      = '0;
    bus.In2      = '0;
    bus.OP       = '0;
    bus.md_op    = '0;
    bus.md_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst hi", bus.hi, 0);
    chk("rst lo", bus.lo, 0);
    chk("rst busy", {31'd0, bus.busy}, 0);
    chk("rst done", {31'd0, bus.done}, 0);
    chk("rst dbz", {31'd0, bus.div_by_zero}, 0);

    foreach (v[i]) begin
      bus.OP  = v[i].op;
      bus.In1 = v[i].a;
      bus.In2 = v[i].b;
      #1;
      chk($sformatf("alu[%0d] result", i), bus.result, v[i].r);
      chk($sformatf("alu[%0d] zero", i),
          {31'd0, bus.zero_flag}, {31'd0, v[i].r == 0});
    end

    md_run("mult", 2'b00, -32'sd3, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1);
    md_run("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    md_run("div_neg", 2'b10, -32'sd7, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("div_negdiv", 2'b10, 32'd7, -32'sd2,
           32'h00000001, 32'hFFFFFFFD);
    md_run("divu", 2'b11, 32'd100, 32'd7,
           32'd2, 32'd14);
    md_run("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000);
    md_run("divu_zero", 2'b11, 32'h1234, 32'h0,
           32'h1234, 32'hFFFFFFFF);
    chk("dbz set", {31'd0, bus.div_by_zero}, 1);
    md_run("mult_after_dz", 2'b00, 32'd6, 32'd7,
           32'd0, 32'd42);

    // second start while busy must be dropped
    @(negedge clock);
    bus.md_op    = 2'b01;
    bus.In1      = 32'd3;
    bus.In2      = 32'd4;
    bus.md_start = 1'b1;
    @(posedge clock);
    #1;
    bus.md_start = 1'b0;
    lat = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      lat++;
    end
    @(negedge clock);
    bus.md_op    = 2'b10;
    bus.In1      = 32'd100;
    bus.In2      = 32'd7;
    bus.md_start = 1'b1;
    @(posedge clock);
    #1;
    lat++;
    bus.md_start = 1'b0;
    while (!bus.done && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("ign latency", lat, 33);
    chk("ign hi", bus.hi, 0);
    chk("ign lo", bus.lo, 12);
    bus.OP = 4'b1110;
    #1;
    chk("ign mflo", bus.result, 12);
    repeat (3) @(posedge clock);
    #1;
    chk("ign no_rerun", {31'd0, bus.busy}, 0);

    // reset in the middle of a multiply
    @(negedge clock);
    bus.md_op    = 2'b00;
    bus.In1      = 32'd7;
    bus.In2      = 32'd9;
    bus.md_start = 1'b1;
    @(posedge clock);
    #1;
    bus.md_start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst busy", {31'd0, bus.busy}, 0);
    chk("mid_rst hi", bus.hi, 0);
    chk("mid_rst lo", bus.lo, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.done) seen++;
    end
    chk("mid_rst no_done", seen, 0);
    chk("mid_rst lo_hold", bus.lo, 0);
    md_run("mult_post_rst", 2'b00, 32'd7, 32'd9,
           32'd0, 32'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
